// File: rtl/sram_master_pkg.sv
// Shared encodings for the SRAM initiator: access sizes, response error codes and FSM states.
package sram_master_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ALIGN   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR    = 2'd2
  } state_e;

  // Request attributes kept for the duration of one access.
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       is_unsigned;
    logic [1:0] offset;
  } req_attr_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      SZ_WORD: return offset != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store replication + lane enables, load lane extraction + extension.
module mem_lane_align
  import sram_master_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be_c,
  output logic [31:0] wdata_c,
  output logic [31:0] rdata_c
);

  logic [4:0]  shamt;
  logic [31:0] shifted;

  assign shamt   = {offset, 3'b000};
  assign shifted = rword >> shamt;

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = wdata;
    rdata_c = rword;
    case (size)
      SZ_BYTE: begin
        be_c    = 4'b0001 << offset;
        wdata_c = {4{wdata[7:0]}};
        rdata_c = is_unsigned ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be_c    = 4'b0011 << offset;
        wdata_c = {2{wdata[15:0]}};
        rdata_c = is_unsigned ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sram_master.sv
// Single-request SRAM initiator: sizes core byte accesses onto the word SRAM,
// drives the sel/we/ack handshake and reports alignment and no-ack errors.
module sram_master
  import sram_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_err,
  output logic                  sel,
  output logic                  we,
  output logic [3:0]            byte_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] dout,
  input  logic                  ack
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  state_e          state, state_nxt;
  req_attr_t       attr_q;
  logic [CNT_W-1:0] cnt_q;

  logic accept, bad_req, ack_hit, timeout_hit;
  logic [1:0]  lane_size, lane_off;
  logic        lane_uns;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, rdata_c;

  logic                  req_ready_n, sel_n, we_n, rsp_valid_n;
  logic [3:0]            byte_en_n;
  logic [1:0]            rsp_err_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] din_n, rsp_rdata_n;

  assign accept      = (state == ST_IDLE) && req_valid;
  assign bad_req     = is_misaligned(req_size, req_addr[1:0]);
  assign ack_hit     = (state == ST_ACCESS) && ack;
  assign timeout_hit = (state == ST_ACCESS) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // The aligner sees the incoming request at accept time and the held request afterwards.
  assign lane_size = (state == ST_IDLE) ? req_size          : attr_q.size;
  assign lane_off  = (state == ST_IDLE) ? req_addr[1:0]     : attr_q.offset;
  assign lane_uns  = (state == ST_IDLE) ? req_unsigned      : attr_q.is_unsigned;

  mem_lane_align u_align (
    .size        (lane_size),
    .offset      (lane_off),
    .is_unsigned (lane_uns),
    .wdata       (req_wdata),
    .rword       (dout),
    .be_c        (be_c),
    .wdata_c     (wdata_c),
    .rdata_c     (rdata_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = bad_req ? ST_ERR : ST_ACCESS;
      ST_ACCESS: if (ack_hit || timeout_hit) state_nxt = ST_IDLE;
      ST_ERR:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_n = (state_nxt == ST_IDLE);
    sel_n       = 1'b0;
    we_n        = 1'b0;
    byte_en_n   = byte_en;
    addr_n      = addr;
    din_n       = din;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = '0;
    rsp_err_n   = ERR_NONE;
    case (state)
      ST_IDLE: begin
        if (accept && !bad_req) begin
          sel_n     = 1'b1;
          we_n      = req_we;
          byte_en_n = req_we ? be_c : 4'b1111;
          addr_n    = {2'b00, req_addr[ADDR_WIDTH-1:2]};
          din_n     = wdata_c;
        end
      end
      ST_ACCESS: begin
        if (ack_hit) begin
          rsp_valid_n = 1'b1;
          rsp_rdata_n = attr_q.we ? '0 : rdata_c;
        end else if (timeout_hit) begin
          rsp_valid_n = 1'b1;
          rsp_err_n   = ERR_TIMEOUT;
        end else begin
          sel_n = 1'b1;
          we_n  = attr_q.we;
        end
      end
      ST_ERR: begin
        rsp_valid_n = 1'b1;
        rsp_err_n   = ERR_ALIGN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready <= 1'b1;
      sel       <= 1'b0;
      we        <= 1'b0;
      byte_en   <= '0;
      addr      <= '0;
      din       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= ERR_NONE;
    end else begin
      req_ready <= req_ready_n;
      sel       <= sel_n;
      we        <= we_n;
      byte_en   <= byte_en_n;
      addr      <= addr_n;
      din       <= din_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err   <= rsp_err_n;
    end
  end

  // Held request attributes and the sel-high cycle counter for the no-ack timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      attr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (accept) attr_q <= '{we: req_we, size: req_size, is_unsigned: req_unsigned, offset: req_addr[1:0]};
      cnt_q <= (state == ST_ACCESS) ? cnt_q + CNT_W'(1) : '0;
    end
  end

endmodule

// File: tb/tb_sram_master.sv
// Directed bench for sram_master against a small behavioural SRAM with rising-edge ack.
module tb_sram_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        sel, we, ack;
  logic [3:0]  byte_en;
  logic [31:0] addr, din, dout;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sel(sel), .we(we), .byte_en(byte_en), .addr(addr), .din(din), .dout(dout), .ack(ack)
  );

  // Behavioural SRAM: access starts on sel rising, ack/dout two edges later.
  logic [31:0] mem [256];
  logic        sel_d = 1'b0, stage1 = 1'b0, ack_en;
  logic [7:0]  ridx = 8'h0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    ack  = 1'b0;
    dout = 32'h0;
  end

  always @(posedge clk) begin
    sel_d  <= sel;
    stage1 <= sel && !sel_d && ack_en;
    ack    <= stage1;
    if (sel && !sel_d) ridx <= addr[7:0];
    dout   <= stage1 ? mem[ridx] : 32'h0;
    if (sel && !sel_d && we) mem[addr[7:0]] <= merge(mem[addr[7:0]], din, byte_en);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] r_rdata, be_seen, din_seen, addr_seen;
  logic [1:0]  r_err;
  int          lat, sel_cyc, we_cyc;

  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
    int k;
    logic got;
    @(negedge clk);
    req_we = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    sel_cyc = 0; we_cyc = 0; lat = -1; got = 1'b0;
    r_rdata = 'x; r_err = 'x; be_seen = 'x; din_seen = 'x; addr_seen = 'x;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (sel) begin sel_cyc++; be_seen = 32'(byte_en); din_seen = din; addr_seen = addr; end
      if (we) we_cyc++;
      if (rsp_valid) begin got = 1'b1; lat = c - 1; r_rdata = rsp_rdata; r_err = rsp_err; end
    end
    check("rsp_seen", 32'(got), 32'd1);
  endtask

  int   nacc, nrsp, gaps, gap_bad, low_run;
  logic seen_hi, drop;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; ack_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_byte_en", 32'(byte_en), 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_din", din, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);

    // Word store 0xDEADBEEF to 0x40
    do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF);
    check("ws_err", 32'(r_err), 32'd0);
    check("ws_lat", 32'(lat), 32'd3);
    check("ws_sel_cyc", 32'(sel_cyc), 32'd3);
    check("ws_we_cyc", 32'(we_cyc), 32'd3);
    check("ws_be", be_seen, 32'hF);
    check("ws_din", din_seen, 32'hDEADBEEF);
    check("ws_addr", addr_seen, 32'h10);
    check("ws_rdata", r_rdata, 32'h0);

    // Word load from 0x40
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    check("wl_rdata", r_rdata, 32'hDEADBEEF);
    check("wl_err", 32'(r_err), 32'd0);
    check("wl_lat", 32'(lat), 32'd3);
    check("wl_we_cyc", 32'(we_cyc), 32'd0);
    check("wl_be", be_seen, 32'hF);

    // Byte store 0xA5 to 0x42, then word readback
    do_req(1'b1, 2'd0, 1'b0, 32'h42, 32'h000000A5);
    check("bs_be", be_seen, 32'h4);
    check("bs_din", din_seen, 32'hA5A5A5A5);
    check("bs_err", 32'(r_err), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    check("bs_readback", r_rdata, 32'hDEA5BEEF);

    // Byte 0x80 into lane 3, then signed/unsigned extraction
    do_req(1'b1, 2'd0, 1'b0, 32'h43, 32'h12345680);
    check("b3_be", be_seen, 32'h8);
    do_req(1'b0, 2'd0, 1'b0, 32'h43, 32'h0);
    check("lb_signed", r_rdata, 32'hFFFFFF80);
    do_req(1'b0, 2'd0, 1'b1, 32'h43, 32'h0);
    check("lb_unsigned", r_rdata, 32'h00000080);
    do_req(1'b0, 2'd0, 1'b0, 32'h41, 32'h0);
    check("lb_signed_l1", r_rdata, 32'hFFFFFFBE);
    do_req(1'b0, 2'd1, 1'b0, 32'h42, 32'h0);
    check("lh_signed_hi", r_rdata, 32'hFFFF80A5);
    do_req(1'b0, 2'd1, 1'b1, 32'h40, 32'h0);
    check("lh_unsigned_lo", r_rdata, 32'h0000BEEF);

    // Half store to upper half of word 0x44
    do_req(1'b1, 2'd1, 1'b0, 32'h46, 32'hFFFF1234);
    check("hs_be", be_seen, 32'hC);
    check("hs_din", din_seen, 32'h12341234);
    check("hs_addr", addr_seen, 32'h11);
    do_req(1'b0, 2'd2, 1'b0, 32'h44, 32'h0);
    check("hs_readback", r_rdata, 32'h12340000);

    // Illegal requests
    do_req(1'b0, 2'd1, 1'b0, 32'h1003, 32'h0);
    check("mis_h_err", 32'(r_err), 32'd1);
    check("mis_h_lat", 32'(lat), 32'd1);
    check("mis_h_sel", 32'(sel_cyc), 32'd0);
    check("mis_h_we", 32'(we_cyc), 32'd0);
    check("mis_h_rdata", r_rdata, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 32'h41, 32'h11111111);
    check("mis_w_err", 32'(r_err), 32'd1);
    check("mis_w_sel", 32'(sel_cyc), 32'd0);
    do_req(1'b0, 2'd3, 1'b0, 32'h40, 32'h0);
    check("size3_err", 32'(r_err), 32'd1);

    // No ack: timeout after 4 sel-high cycles, then normal access
    ack_en = 1'b0;
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    check("to_err", 32'(r_err), 32'd2);
    check("to_rdata", r_rdata, 32'h0);
    check("to_sel_cyc", 32'(sel_cyc), 32'd4);
    check("to_lat", 32'(lat), 32'd4);
    ack_en = 1'b1;
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    check("post_to_rdata", r_rdata, 32'h80A5BEEF);
    check("post_to_err", 32'(r_err), 32'd0);

    // Three back-to-back loads with req_valid held
    @(posedge clk); #1;
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h40; req_valid = 1'b1;
    nacc = 0; nrsp = 0; gaps = 0; gap_bad = 0; low_run = 0; seen_hi = 1'b0; drop = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sel) begin
        if (seen_hi && low_run > 0) begin gaps++; if (low_run != 1) gap_bad++; end
        low_run = 0; seen_hi = 1'b1;
      end else if (seen_hi) low_run++;
      if (rsp_valid) nrsp++;
      if (req_valid && req_ready) begin nacc++; if (nacc == 3) drop = 1'b1; end
      @(posedge clk); #1;
      if (drop) req_valid = 1'b0;
    end
    check("b2b_accepts", 32'(nacc), 32'd3);
    check("b2b_rsps", 32'(nrsp), 32'd3);
    check("b2b_gaps", 32'(gaps), 32'd2);
    check("b2b_gap_len", 32'(gap_bad), 32'd0);

    // Reset during ACCESS drops the request silently
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd2; req_addr = 32'h80; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("ra_sel_before", 32'(sel), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ra_sel", 32'(sel), 32'd0);
    check("ra_we", 32'(we), 32'd0);
    check("ra_byte_en", 32'(byte_en), 32'd0);
    check("ra_din", din, 32'd0);
    nrsp = 0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid) nrsp++;
      @(negedge clk);
    end
    check("ra_no_rsp", 32'(nrsp), 32'd0);
    check("ra_ready", 32'(req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
